editor_campos: RTL and testbench

EDITOR_CAMPOS -- requirements
Module: editor_campos

---
 rtl/editor_campos.sv | 203 ++++++++++++++++++++
 tb/tb_editor_campos.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/editor_campos.sv
// editor_campos: push-button editor for RTC date/time/alarm fields.
// Navigates a ring of nine BCD fields, edits the selected value with
// range-aware BCD wrap, and hands the result to the RTC controller as a
// request/acknowledge write.
module editor_campos #(
  parameter int unsigned TIMEOUT_CYC = 32'd1000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_UP,
  input  logic       BTN_DOWN,
  input  logic       BTN_LEFT,
  input  logic       BTN_RIGHT,
  input  logic       BTN_EDIT,
  input  logic [7:0] DIA_T,
  input  logic [7:0] MES_T,
  input  logic [7:0] ANO_T,
  input  logic [7:0] HORA_T,
  input  logic [7:0] MINUTO_T,
  input  logic [7:0] SEGUNDO_T,
  input  logic [7:0] HORAT_T,
  input  logic [7:0] MINUTOT_T,
  input  logic [7:0] SEGUNDOT_T,
  input  logic       WR_ACK,
  output logic [7:0] Puntero,
  output logic [7:0] DATO_W,
  output logic [7:0] DIR_W,
  output logic       WR_REQ,
  output logic       EDITANDO
);

  localparam int unsigned CW = 32;
  localparam int unsigned IW = 4;
  localparam logic [IW-1:0] LAST_IDX = IW'(8);

  typedef enum logic [1:0] {S_IDLE, S_NAV, S_EDIT, S_WRITE} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   cnt;

  logic            any_btn;
  logic            timed_out;
  logic [7:0]      sel_raw;
  logic [7:0]      fmin;
  logic [7:0]      fmax;
  logic [7:0]      load_val;
  logic [7:0]      inc_val;
  logic [7:0]      dec_val;
  logic [IW-1:0]   next_idx;
  logic [IW-1:0]   prev_idx;

  // RTC register address of each ring position
  function automatic logic [7:0] field_addr(input logic [IW-1:0] i);
    case (i)
      4'd0:    return 8'h24;
      4'd1:    return 8'h25;
      4'd2:    return 8'h26;
      4'd3:    return 8'h23;
      4'd4:    return 8'h22;
      4'd5:    return 8'h21;
      4'd6:    return 8'h43;
      4'd7:    return 8'h42;
      default: return 8'h41;
    endcase
  endfunction

  // Field selection, range limits, load validation and BCD step values
  always_comb begin
    sel_raw  = SEGUNDOT_T;
    fmin     = 8'h00;
    fmax     = 8'h59;
    case (idx)
      4'd0:    begin sel_raw = DIA_T;     fmin = 8'h01; fmax = 8'h31; end
      4'd1:    begin sel_raw = MES_T;     fmin = 8'h01; fmax = 8'h12; end
      4'd2:    begin sel_raw = ANO_T;     fmax = 8'h99; end
      4'd3:    begin sel_raw = HORA_T;    fmax = 8'h23; end
      4'd4:    sel_raw = MINUTO_T;
      4'd5:    sel_raw = SEGUNDO_T;
      4'd6:    begin sel_raw = HORAT_T;   fmax = 8'h23; end
      4'd7:    sel_raw = MINUTOT_T;
      default: sel_raw = SEGUNDOT_T;
    endcase

    // Nibbles both <=9 makes hex ordering equal to decimal ordering
    if ((sel_raw[7:4] <= 4'd9) && (sel_raw[3:0] <= 4'd9) &&
        (sel_raw >= fmin) && (sel_raw <= fmax))
      load_val = sel_raw;
    else
      load_val = fmin;

    if (DATO_W == fmax)
      inc_val = fmin;
    else if (DATO_W[3:0] == 4'd9)
      inc_val = {DATO_W[7:4] + 4'd1, 4'd0};
    else
      inc_val = DATO_W + 8'd1;

    if (DATO_W == fmin)
      dec_val = fmax;
    else if (DATO_W[3:0] == 4'd0)
      dec_val = {DATO_W[7:4] - 4'd1, 4'd9};
    else
      dec_val = DATO_W - 8'd1;

    next_idx  = (idx == LAST_IDX) ? '0 : idx + IW'(1);
    prev_idx  = (idx == '0) ? LAST_IDX : idx - IW'(1);
    any_btn   = BTN_UP | BTN_DOWN | BTN_LEFT | BTN_RIGHT | BTN_EDIT;
    timed_out = (cnt == CW'(TIMEOUT_CYC - 32'd1));
  end

  // Editor FSM with registered outputs; priority EDIT > LEFT > RIGHT > UP > DOWN
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      idx      <= '0;
      cnt      <= '0;
      Puntero  <= 8'h00;
      DATO_W   <= 8'h00;
      DIR_W    <= 8'h00;
      WR_REQ   <= 1'b0;
      EDITANDO <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_btn) begin
            state   <= S_NAV;
            idx     <= '0;
            Puntero <= field_addr('0);
            cnt     <= '0;
          end
        end

        S_NAV: begin
          if (BTN_EDIT) begin
            state    <= S_EDIT;
            DATO_W   <= load_val;
            EDITANDO <= 1'b1;
            cnt      <= '0;
          end else if (BTN_LEFT) begin
            idx     <= prev_idx;
            Puntero <= field_addr(prev_idx);
            cnt     <= '0;
          end else if (BTN_RIGHT) begin
            idx     <= next_idx;
            Puntero <= field_addr(next_idx);
            cnt     <= '0;
          end else if (any_btn) begin
            cnt <= '0;
          end else if (timed_out) begin
            state   <= S_IDLE;
            Puntero <= 8'h00;
            cnt     <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_EDIT: begin
          if (BTN_EDIT) begin
            state    <= S_WRITE;
            DIR_W    <= Puntero;
            WR_REQ   <= 1'b1;
            EDITANDO <= 1'b0;
            cnt      <= '0;
          end else if (BTN_LEFT) begin
            state    <= S_NAV;
            EDITANDO <= 1'b0;
            cnt      <= '0;
          end else if (BTN_RIGHT) begin
            cnt <= '0;
          end else if (BTN_UP) begin
            DATO_W <= inc_val;
            cnt    <= '0;
          end else if (BTN_DOWN) begin
            DATO_W <= dec_val;
            cnt    <= '0;
          end else if (timed_out) begin
            state    <= S_IDLE;
            Puntero  <= 8'h00;
            EDITANDO <= 1'b0;
            cnt      <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_WRITE: begin
          if (WR_ACK) begin
            state  <= S_NAV;
            WR_REQ <= 1'b0;
            cnt    <= '0;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_editor_campos.sv
// tb_editor_campos: directed scenarios plus randomized traffic checked
// against a decimal-arithmetic reference model of the field editor.
module tb_editor_campos;

  localparam int TMO = 16;

  logic       CLK = 1'b0;
  logic       RST, BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT, BTN_EDIT, WR_ACK;
  logic [7:0] DIA_T, MES_T, ANO_T, HORA_T, MINUTO_T, SEGUNDO_T;
  logic [7:0] HORAT_T, MINUTOT_T, SEGUNDOT_T;
  logic [7:0] Puntero, DATO_W, DIR_W;
  logic       WR_REQ, EDITANDO;

  editor_campos #(.TIMEOUT_CYC(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .BTN_UP(BTN_UP), .BTN_DOWN(BTN_DOWN), .BTN_LEFT(BTN_LEFT),
    .BTN_RIGHT(BTN_RIGHT), .BTN_EDIT(BTN_EDIT),
    .DIA_T(DIA_T), .MES_T(MES_T), .ANO_T(ANO_T), .HORA_T(HORA_T),
    .MINUTO_T(MINUTO_T), .SEGUNDO_T(SEGUNDO_T), .HORAT_T(HORAT_T),
    .MINUTOT_T(MINUTOT_T), .SEGUNDOT_T(SEGUNDOT_T),
    .WR_ACK(WR_ACK),
    .Puntero(Puntero), .DATO_W(DATO_W), .DIR_W(DIR_W),
    .WR_REQ(WR_REQ), .EDITANDO(EDITANDO)
  );

  always #5 CLK = ~CLK;

  // button vector order {edit, left, right, up, down}
  localparam logic [4:0] B_NONE  = 5'b00000;
  localparam logic [4:0] B_EDIT  = 5'b10000;
  localparam logic [4:0] B_LEFT  = 5'b01000;
  localparam logic [4:0] B_RIGHT = 5'b00100;
  localparam logic [4:0] B_UP    = 5'b00010;
  localparam logic [4:0] B_DOWN  = 5'b00001;

  int n_checks = 0;
  int n_pass   = 0;

  // ring tables: address, decimal minimum, decimal maximum
  int f_addr [9] = '{'h24, 'h25, 'h26, 'h23, 'h22, 'h21, 'h43, 'h42, 'h41};
  int f_min  [9] = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
  int f_max  [9] = '{31, 12, 99, 23, 59, 59, 23, 59, 59};

  localparam int M_IDLE = 0, M_NAV = 1, M_EDIT = 2, M_WRITE = 3;
  int         m_mode, m_fld, m_idle;
  logic [7:0] m_dato, m_dir;
  logic       m_req;

  function automatic logic [7:0] field_input(int f);
    case (f)
      0: return DIA_T;     1: return MES_T;     2: return ANO_T;
      3: return HORA_T;    4: return MINUTO_T;  5: return SEGUNDO_T;
      6: return HORAT_T;   7: return MINUTOT_T; default: return SEGUNDOT_T;
    endcase
  endfunction

  function automatic int bcd2dec(logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] dec2bcd(int d);
    return 8'(((d / 10) << 4) | (d % 10));
  endfunction

  function automatic logic [7:0] exp_punt();
    return (m_mode == M_IDLE) ? 8'h00 : 8'(f_addr[m_fld]);
  endfunction

  // Reference behaviour for one clock edge, working in decimal field values
  task automatic model_apply(input logic [4:0] b, input logic ack, input logic rst);
    logic [7:0] raw;
    int d;
    if (rst) begin
      m_mode = M_IDLE; m_fld = 0; m_idle = 0;
      m_dato = 8'h00; m_dir = 8'h00; m_req = 1'b0;
      return;
    end
    case (m_mode)
      M_IDLE: if (b != 0) begin m_mode = M_NAV; m_fld = 0; m_idle = 0; end
      M_NAV, M_EDIT: begin
        if (b[4]) begin
          if (m_mode == M_NAV) begin
            raw = field_input(m_fld);
            d = bcd2dec(raw);
            if (raw[7:4] > 9 || raw[3:0] > 9 || d < f_min[m_fld] || d > f_max[m_fld])
              m_dato = dec2bcd(f_min[m_fld]);
            else
              m_dato = raw;
            m_mode = M_EDIT;
          end else begin
            m_dir = 8'(f_addr[m_fld]); m_req = 1'b1; m_mode = M_WRITE;
          end
          m_idle = 0;
        end else if (b[3]) begin
          if (m_mode == M_NAV) m_fld = (m_fld + 8) % 9;
          else m_mode = M_NAV;
          m_idle = 0;
        end else if (b[2]) begin
          if (m_mode == M_NAV) m_fld = (m_fld + 1) % 9;
          m_idle = 0;
        end else if (b != 0) begin
          if (m_mode == M_EDIT) begin
            d = bcd2dec(m_dato);
            if (b[1]) d = (d == f_max[m_fld]) ? f_min[m_fld] : d + 1;
            else      d = (d == f_min[m_fld]) ? f_max[m_fld] : d - 1;
            m_dato = dec2bcd(d);
          end
          m_idle = 0;
        end else begin
          m_idle++;
          if (m_idle >= TMO) begin m_mode = M_IDLE; m_idle = 0; end
        end
      end
      default: if (ack) begin m_req = 1'b0; m_mode = M_NAV; m_idle = 0; end
    endcase
  endtask

  // One clock: drive pulses, update the model at the edge, sample 1 time unit later
  task automatic step(input logic [4:0] b, input logic ack, input logic rst);
    {BTN_EDIT, BTN_LEFT, BTN_RIGHT, BTN_UP, BTN_DOWN} = b;
    WR_ACK = ack;
    RST    = rst;
    @(posedge CLK);
    model_apply(b, ack, rst);
    #1;
    {BTN_EDIT, BTN_LEFT, BTN_RIGHT, BTN_UP, BTN_DOWN} = B_NONE;
    WR_ACK = 1'b0;
    RST    = 1'b0;
  endtask

  task automatic test_reset();
    step(B_NONE, 1'b0, 1'b1);
    step(B_RIGHT, 1'b1, 1'b1);
    n_checks++;
    if ({Puntero, DATO_W, DIR_W, WR_REQ, EDITANDO} !== 26'd0)
      $display("FAIL reset_outputs got %h/%h/%h/%b/%b want all zero",
               Puntero, DATO_W, DIR_W, WR_REQ, EDITANDO);
    else n_pass++;
  endtask

  task automatic test_ring();
    logic [7:0] exp_seq [10] = '{8'h24, 8'h25, 8'h26, 8'h23, 8'h22,
                                 8'h21, 8'h43, 8'h42, 8'h41, 8'h24};
    for (int i = 0; i < 10; i++) begin
      step(B_RIGHT, 1'b0, 1'b0);
      n_checks++;
      if (Puntero !== exp_seq[i])
        $display("FAIL ring_right%0d got %h want %h", i, Puntero, exp_seq[i]);
      else n_pass++;
    end
    step(B_LEFT, 1'b0, 1'b0);
    n_checks++;
    if (Puntero !== 8'h41) $display("FAIL ring_left_wrap got %h want 41", Puntero);
    else n_pass++;
  endtask

  task automatic test_load_edit();
    MES_T = 8'h12; DIA_T = 8'h01; HORA_T = 8'h3A; ANO_T = 8'h09;
    step(B_RIGHT, 1'b0, 1'b0);
    step(B_RIGHT, 1'b0, 1'b0);
    step(B_EDIT, 1'b0, 1'b0);
    n_checks++;
    if (DATO_W !== 8'h12 || EDITANDO !== 1'b1 || Puntero !== 8'h25)
      $display("FAIL load_mes got %h/%b/%h want 12/1/25", DATO_W, EDITANDO, Puntero);
    else n_pass++;
    step(B_UP, 1'b0, 1'b0);
    n_checks++;
    if (DATO_W !== 8'h01) $display("FAIL mes_up_wrap got %h want 01", DATO_W);
    else n_pass++;
    step(B_DOWN, 1'b0, 1'b0);
    n_checks++;
    if (DATO_W !== 8'h12) $display("FAIL mes_down_wrap got %h want 12", DATO_W);
    else n_pass++;
    step(B_LEFT, 1'b0, 1'b0);
    step(B_LEFT, 1'b0, 1'b0);
    step(B_EDIT, 1'b0, 1'b0);
    step(B_DOWN, 1'b0, 1'b0);
    n_checks++;
    if (DATO_W !== 8'h31 || Puntero !== 8'h24)
      $display("FAIL dia_down_wrap got %h@%h want 31@24", DATO_W, Puntero);
    else n_pass++;
    step(B_LEFT, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(B_RIGHT, 1'b0, 1'b0);
    step(B_EDIT, 1'b0, 1'b0);
    n_checks++;
    if (DATO_W !== 8'h00 || Puntero !== 8'h23)
      $display("FAIL hora_invalid_load got %h@%h want 00@23", DATO_W, Puntero);
    else n_pass++;
    step(B_LEFT, 1'b0, 1'b0);
    step(B_LEFT, 1'b0, 1'b0);
    step(B_EDIT, 1'b0, 1'b0);
    step(B_UP, 1'b0, 1'b0);
    n_checks++;
    if (DATO_W !== 8'h10) $display("FAIL bcd_carry got %h want 10", DATO_W);
    else n_pass++;
    step(B_DOWN, 1'b0, 1'b0);
    n_checks++;
    if (DATO_W !== 8'h09) $display("FAIL bcd_borrow got %h want 09", DATO_W);
    else n_pass++;
    step(B_LEFT, 1'b0, 1'b0);
  endtask

  task automatic test_write();
    step(B_NONE, 1'b0, 1'b1);
    step(B_UP, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(B_RIGHT, 1'b0, 1'b0);
    SEGUNDO_T = 8'h44;
    step(B_EDIT, 1'b0, 1'b0);
    step(B_UP, 1'b0, 1'b0);
    step(B_EDIT, 1'b0, 1'b0);
    n_checks++;
    if (WR_REQ !== 1'b1 || DIR_W !== 8'h21 || DATO_W !== 8'h45 || EDITANDO !== 1'b0)
      $display("FAIL write_issue got req=%b dir=%h dato=%h ed=%b want 1/21/45/0",
               WR_REQ, DIR_W, DATO_W, EDITANDO);
    else n_pass++;
    // held longer than the timeout with buttons hammering: request must not move
    for (int i = 0; i < 20; i++) begin
      step(5'($urandom), 1'b0, 1'b0);
      n_checks++;
      if ({WR_REQ, DIR_W, DATO_W, Puntero} !== {1'b1, 8'h21, 8'h45, 8'h21})
        $display("FAIL write_hold%0d got req=%b dir=%h dato=%h ptr=%h want 1/21/45/21",
                 i, WR_REQ, DIR_W, DATO_W, Puntero);
      else n_pass++;
    end
    step(B_NONE, 1'b1, 1'b0);
    n_checks++;
    if (WR_REQ !== 1'b0 || Puntero !== 8'h21 || EDITANDO !== 1'b0)
      $display("FAIL write_ack got req=%b ptr=%h ed=%b want 0/21/0", WR_REQ, Puntero, EDITANDO);
    else n_pass++;
    step(B_RIGHT, 1'b0, 1'b0);
    n_checks++;
    if (Puntero !== 8'h43) $display("FAIL nav_after_write got %h want 43", Puntero);
    else n_pass++;
    step(B_NONE, 1'b1, 1'b0);
    n_checks++;
    if (WR_REQ !== 1'b0 || Puntero !== 8'h43 || DIR_W !== 8'h21)
      $display("FAIL stray_ack got req=%b ptr=%h dir=%h want 0/43/21", WR_REQ, Puntero, DIR_W);
    else n_pass++;
  endtask

  task automatic test_priority();
    HORAT_T = 8'h22;
    step(B_EDIT, 1'b0, 1'b0);
    step(B_EDIT | B_UP, 1'b0, 1'b0);
    n_checks++;
    if (WR_REQ !== 1'b1 || DATO_W !== 8'h22 || DIR_W !== 8'h43)
      $display("FAIL edit_beats_up got req=%b dato=%h dir=%h want 1/22/43", WR_REQ, DATO_W, DIR_W);
    else n_pass++;
    step(B_NONE, 1'b1, 1'b0);
    step(B_EDIT, 1'b0, 1'b0);
    step(B_RIGHT | B_UP | B_DOWN, 1'b0, 1'b0);
    n_checks++;
    if (DATO_W !== 8'h22 || Puntero !== 8'h43 || EDITANDO !== 1'b1)
      $display("FAIL right_beats_up got dato=%h ptr=%h ed=%b want 22/43/1", DATO_W, Puntero, EDITANDO);
    else n_pass++;
    step(B_LEFT | B_UP, 1'b0, 1'b0);
    step(B_NONE, 1'b0, 1'b0);
    n_checks++;
    if (WR_REQ !== 1'b0 || EDITANDO !== 1'b0 || DATO_W !== 8'h22 || Puntero !== 8'h43)
      $display("FAIL left_cancel got req=%b ed=%b dato=%h ptr=%h want 0/0/22/43",
               WR_REQ, EDITANDO, DATO_W, Puntero);
    else n_pass++;
    step(B_LEFT | B_RIGHT, 1'b0, 1'b0);
    n_checks++;
    if (Puntero !== 8'h21) $display("FAIL left_beats_right got %h want 21", Puntero);
    else n_pass++;
  endtask

  task automatic test_timeout();
    step(B_EDIT, 1'b0, 1'b0);
    for (int i = 0; i < TMO - 1; i++) step(B_NONE, 1'b0, 1'b0);
    n_checks++;
    if (EDITANDO !== 1'b1) $display("FAIL timeout_early got ed=%b want 1", EDITANDO);
    else n_pass++;
    step(B_NONE, 1'b0, 1'b0);
    n_checks++;
    if (EDITANDO !== 1'b0 || Puntero !== 8'h00 || WR_REQ !== 1'b0)
      $display("FAIL timeout_idle got ed=%b ptr=%h req=%b want 0/00/0", EDITANDO, Puntero, WR_REQ);
    else n_pass++;
    step(B_DOWN, 1'b0, 1'b0);
    step(B_EDIT, 1'b0, 1'b0);
    step(B_EDIT, 1'b0, 1'b0);
    step(B_NONE, 1'b0, 1'b1);
    n_checks++;
    if ({Puntero, DATO_W, DIR_W, WR_REQ, EDITANDO} !== 26'd0)
      $display("FAIL reset_mid_write got %h/%h/%h/%b/%b want all zero",
               Puntero, DATO_W, DIR_W, WR_REQ, EDITANDO);
    else n_pass++;
    step(B_NONE, 1'b1, 1'b0);
    n_checks++;
    if (WR_REQ !== 1'b0 || Puntero !== 8'h00)
      $display("FAIL no_retry got req=%b ptr=%h want 0/00", WR_REQ, Puntero);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [4:0] b;
    logic       ack, rst, quiet;
    logic [7:0] v;
    quiet = 1'b0;
    step(B_NONE, 1'b0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(49) == 0) quiet = ~quiet;
      b   = (!quiet && $urandom_range(2) == 0) ? 5'($urandom) : B_NONE;
      ack = ($urandom_range(4) == 0);
      rst = ($urandom_range(299) == 0);
      if ($urandom_range(7) == 0) begin
        v = ($urandom_range(1) == 0) ? 8'($urandom)
                                     : dec2bcd(int'($urandom_range(99)));
        case ($urandom_range(8))
          0: DIA_T = v;     1: MES_T = v;     2: ANO_T = v;
          3: HORA_T = v;    4: MINUTO_T = v;  5: SEGUNDO_T = v;
          6: HORAT_T = v;   7: MINUTOT_T = v; default: SEGUNDOT_T = v;
        endcase
      end
      step(b, ack, rst);
      n_checks++;
      if ({Puntero, DATO_W, DIR_W, WR_REQ, EDITANDO} !==
          {exp_punt(), m_dato, m_dir, m_req, (m_mode == M_EDIT)})
        $display("FAIL random%0d got %h/%h/%h/%b/%b want %h/%h/%h/%b/%b", i,
                 Puntero, DATO_W, DIR_W, WR_REQ, EDITANDO,
                 exp_punt(), m_dato, m_dir, m_req, (m_mode == M_EDIT));
      else n_pass++;
    end
  endtask

  initial begin
    RST = 1'b1; WR_ACK = 1'b0;
    {BTN_EDIT, BTN_LEFT, BTN_RIGHT, BTN_UP, BTN_DOWN} = B_NONE;
    DIA_T = 8'h15; MES_T = 8'h06; ANO_T = 8'h24; HORA_T = 8'h10;
    MINUTO_T = 8'h30; SEGUNDO_T = 8'h00; HORAT_T = 8'h07;
    MINUTOT_T = 8'h45; SEGUNDOT_T = 8'h59;
    m_mode = M_IDLE; m_fld = 0; m_idle = 0;
    m_dato = 8'h00; m_dir = 8'h00; m_req = 1'b0;
    test_reset();
    test_ring();
    test_load_edit();
    test_write();
    test_priority();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
